// File: rtl/control_sequencer.sv
// Hardwired Mini-SRC control unit: Moore FSM stepping fetch T0-T2 and per-opcode
// execute steps T3-T7, producing every Datapath control strobe.
module control_sequencer #(
    parameter int unsigned OPW = 5
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [OPW-1:0] ir_op,
    input  logic           con_ff,
    input  logic           stop,
    output logic           PCout,
    output logic           Zhighout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           HIout,
    output logic           LOout,
    output logic           InPortout,
    output logic           Cout,
    output logic           BAout,
    output logic           Rout,
    output logic           PCin,
    output logic           MARin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           Zhighin,
    output logic           Zlowin,
    output logic           HIin,
    output logic           LOin,
    output logic           OutPortin,
    output logic           InPortin,
    output logic           CONin,
    output logic           Rin,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           IncPC,
    output logic           Read,
    output logic           Write,
    output logic           run
);

    localparam logic [OPW-1:0] OpLd   = OPW'(0),  OpLdi  = OPW'(1),  OpSt   = OPW'(2);
    localparam logic [OPW-1:0] OpAdd  = OPW'(3),  OpSub  = OPW'(4),  OpShr  = OPW'(5);
    localparam logic [OPW-1:0] OpShl  = OPW'(6),  OpRor  = OPW'(7),  OpRol  = OPW'(8);
    localparam logic [OPW-1:0] OpAnd  = OPW'(9),  OpOr   = OPW'(10), OpAddi = OPW'(11);
    localparam logic [OPW-1:0] OpAndi = OPW'(12), OpOri  = OPW'(13), OpMul  = OPW'(14);
    localparam logic [OPW-1:0] OpDiv  = OPW'(15), OpNeg  = OPW'(16), OpNot  = OPW'(17);
    localparam logic [OPW-1:0] OpBr   = OPW'(18), OpJr   = OPW'(19), OpJal  = OPW'(20);
    localparam logic [OPW-1:0] OpIn   = OPW'(21), OpOut  = OPW'(22), OpMfhi = OPW'(23);
    localparam logic [OPW-1:0] OpMflo = OPW'(24), OpHalt = OPW'(26);

    typedef enum logic [3:0] {
        StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalted
    } state_e;

    state_e state_q, state_d;
    logic   last;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state_q <= StReset;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset:  state_d = StT0;
            StT0:     state_d = StT1;
            StT1:     state_d = StT2;
            StT2:     state_d = StT3;
            StHalted: state_d = StHalted;
            default: begin
                if (last) begin
                    state_d = (ir_op == OpHalt || stop) ? StHalted : StT0;
                end else begin
                    case (state_q)
                        StT3:    state_d = StT4;
                        StT4:    state_d = StT5;
                        StT5:    state_d = StT6;
                        default: state_d = StT7;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout} = '0;
        {PCin, MARin, MDRin, IRin, Yin, Zhighin, Zlowin, HIin, LOin} = '0;
        {OutPortin, InPortin, CONin, Rin, Gra, Grb, Grc, IncPC, Read, Write} = '0;
        run  = 1'b0;
        last = 1'b0;
        case (state_q)
            StReset, StHalted: ;
            StT0: begin run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
            StT1: begin run = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            StT2: begin run = 1'b1; MDRout = 1'b1; IRin = 1'b1; end
            default: begin
                run = 1'b1;
                // Execute steps; each arm flags its final step via last.
                case (ir_op)
                    OpAdd, OpSub, OpShr, OpShl, OpRor, OpRol, OpAnd, OpOr,
                    OpAddi, OpAndi, OpOri: begin
                        case (state_q)
                            StT3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                            StT4: begin
                                Zlowin = 1'b1;
                                if (ir_op >= OpAddi) Cout = 1'b1;
                                else begin Grc = 1'b1; Rout = 1'b1; end
                            end
                            default: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
                        endcase
                    end
                    OpMul, OpDiv: begin
                        case (state_q)
                            StT3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                            StT4: begin Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; Zhighin = 1'b1; end
                            StT5: begin Zlowout = 1'b1; LOin = 1'b1; end
                            default: begin Zhighout = 1'b1; HIin = 1'b1; last = 1'b1; end
                        endcase
                    end
                    OpNeg, OpNot: begin
                        if (state_q == StT3) begin Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; end
                        else begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
                    end
                    OpLd, OpLdi, OpSt: begin
                        case (state_q)
                            StT3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                            StT4: begin Cout = 1'b1; Zlowin = 1'b1; end
                            StT5: begin
                                Zlowout = 1'b1;
                                if (ir_op == OpLdi) begin Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
                                else MARin = 1'b1;
                            end
                            StT6: begin
                                MDRin = 1'b1;
                                if (ir_op == OpSt) begin Gra = 1'b1; Rout = 1'b1; end
                                else Read = 1'b1;
                            end
                            default: begin
                                last = 1'b1;
                                if (ir_op == OpSt) Write = 1'b1;
                                else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                            end
                        endcase
                    end
                    OpBr: begin
                        case (state_q)
                            StT3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                            StT4: begin PCout = 1'b1; Yin = 1'b1; end
                            StT5: begin Cout = 1'b1; Zlowin = 1'b1; end
                            default: begin
                                last = 1'b1;
                                if (con_ff) begin Zlowout = 1'b1; PCin = 1'b1; end
                            end
                        endcase
                    end
                    OpJr: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; last = 1'b1; end
                    OpJal: begin
                        if (state_q == StT3) begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                        else begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; last = 1'b1; end
                    end
                    OpIn:    begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
                    OpOut:   begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; last = 1'b1; end
                    OpMfhi:  begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
                    OpMflo:  begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
                    default: last = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: checks the full strobe vector at every step.
module tb_control_sequencer;

    logic clock, clear, con_ff, stop;
    logic [4:0] ir_op;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
    logic PCin, MARin, MDRin, IRin, Yin, Zhighin, Zlowin, HIin, LOin, OutPortin, InPortin;
    logic CONin, Rin, Gra, Grb, Grc, IncPC, Read, Write, run;

    int checks = 0;
    int errors = 0;

    localparam logic [29:0] PCO = 30'd1 << 0,  ZHO = 30'd1 << 1,  ZLO = 30'd1 << 2;
    localparam logic [29:0] MDO = 30'd1 << 3,  HIO = 30'd1 << 4,  LOO = 30'd1 << 5;
    localparam logic [29:0] IPO = 30'd1 << 6,  CO  = 30'd1 << 7,  BAO = 30'd1 << 8;
    localparam logic [29:0] RO  = 30'd1 << 9,  PCI = 30'd1 << 10, MARI = 30'd1 << 11;
    localparam logic [29:0] MDI = 30'd1 << 12, IRI = 30'd1 << 13, YI  = 30'd1 << 14;
    localparam logic [29:0] ZHI = 30'd1 << 15, ZLI = 30'd1 << 16, HII = 30'd1 << 17;
    localparam logic [29:0] LOI = 30'd1 << 18, OPI = 30'd1 << 19, IPI = 30'd1 << 20;
    localparam logic [29:0] CNI = 30'd1 << 21, RI  = 30'd1 << 22, GA  = 30'd1 << 23;
    localparam logic [29:0] GB  = 30'd1 << 24, GC  = 30'd1 << 25, INC = 30'd1 << 26;
    localparam logic [29:0] RD  = 30'd1 << 27, WR  = 30'd1 << 28, RN  = 30'd1 << 29;
    localparam logic [29:0] FETCH0 = PCO | MARI | INC | PCI | RN;

    logic [29:0] obs;
    assign obs = {run, Write, Read, IncPC, Grc, Grb, Gra, Rin, CONin, InPortin, OutPortin,
                  LOin, HIin, Zlowin, Zhighin, Yin, IRin, MDRin, MARin, PCin, Rout, BAout,
                  Cout, InPortout, LOout, HIout, MDRout, Zlowout, Zhighout, PCout};

    control_sequencer #(.OPW(5)) dut (
        .clock(clock), .clear(clear), .ir_op(ir_op), .con_ff(con_ff), .stop(stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
        .Rout(Rout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Zhighin(Zhighin), .Zlowin(Zlowin), .HIin(HIin), .LOin(LOin),
        .OutPortin(OutPortin), .InPortin(InPortin), .CONin(CONin), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
        .run(run)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [29:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [29:0] exp);
        @(posedge clock);
        #1;
        check(tag, exp);
    endtask

    // Memory strobes must never overlap, whatever the bench is doing.
    always @(negedge clock) begin
        checks++;
        assert (!(Read === 1'b1 && Write === 1'b1)) else begin
            errors++;
            $error("FAIL rd_wr_overlap: observed Read=%b Write=%b expected not both 1", Read, Write);
        end
    end

    task automatic fetch12();
        step("fetch_t1", RD | MDI | RN);
        step("fetch_t2", MDO | IRI | RN);
    endtask

    initial begin
        clear = 1'b1; ir_op = 5'b00000; con_ff = 1'b0; stop = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        check("reset_held", '0);
        clear = 1'b0;
        #1 check("reset_after_release", '0);
        step("t0_after_reset", FETCH0);

        // ld interrupted by clear in T5
        ir_op = 5'b00000;
        fetch12();
        step("ld_t3", GB | BAO | YI | RN);
        step("ld_t4", CO | ZLI | RN);
        step("ld_t5", ZLO | MARI | RN);
        #2 clear = 1'b1;
        #1 check("clear_mid_ld", '0);
        step("clear_held", '0);
        clear = 1'b0;
        step("t0_after_clear", FETCH0);

        // jr
        ir_op = 5'b10011;
        fetch12();
        step("jr_t3", GA | RO | PCI | RN);
        step("jr_back_t0", FETCH0);

        // br not taken, then taken
        ir_op = 5'b10010; con_ff = 1'b0;
        fetch12();
        step("br_t3", GA | RO | CNI | RN);
        step("br_t4", PCO | YI | RN);
        step("br_t5", CO | ZLI | RN);
        step("br_t6_nt", RN);
        step("br_nt_t0", FETCH0);
        con_ff = 1'b1;
        fetch12();
        step("br_t3b", GA | RO | CNI | RN);
        step("br_t4b", PCO | YI | RN);
        step("br_t5b", CO | ZLI | RN);
        step("br_t6_tk", ZLO | PCI | RN);
        step("br_tk_t0", FETCH0);
        con_ff = 1'b0;

        // st
        ir_op = 5'b00010;
        fetch12();
        step("st_t3", GB | BAO | YI | RN);
        step("st_t4", CO | ZLI | RN);
        step("st_t5", ZLO | MARI | RN);
        step("st_t6", GA | RO | MDI | RN);
        step("st_t7", WR | RN);
        step("st_t0", FETCH0);

        // mul: T0 back to T0 in 7 clocks
        ir_op = 5'b01110;
        fetch12();
        step("mul_t3", GA | RO | YI | RN);
        step("mul_t4", GB | RO | ZLI | ZHI | RN);
        step("mul_t5", ZLO | LOI | RN);
        step("mul_t6", ZHO | HII | RN);
        step("mul_t0", FETCH0);

        // addi then jal
        ir_op = 5'b01011;
        fetch12();
        step("addi_t3", GB | RO | YI | RN);
        step("addi_t4", CO | ZLI | RN);
        step("addi_t5", ZLO | GA | RI | RN);
        step("addi_t0", FETCH0);
        ir_op = 5'b10100;
        fetch12();
        step("jal_t3", PCO | GB | RI | RN);
        step("jal_t4", GA | RO | PCI | RN);
        step("jal_t0", FETCH0);

        // add with stop held: stop ignored until the last step, then halt
        ir_op = 5'b00011; stop = 1'b1;
        step("add_stop_t1", RD | MDI | RN);
        step("add_stop_t2", MDO | IRI | RN);
        step("add_t3", GB | RO | YI | RN);
        step("add_t4", GC | RO | ZLI | RN);
        step("add_t5", ZLO | GA | RI | RN);
        step("add_stop_halted", '0);
        stop = 1'b0;
        step("halted_stays", '0);
        step("halted_stays2", '0);
        clear = 1'b1;
        step("halt_clear", '0);
        clear = 1'b0;
        step("halt_exit_t0", FETCH0);

        // halt instruction
        ir_op = 5'b11010;
        fetch12();
        step("halt_t3", RN);
        for (int i = 0; i < 20; i++) step("halt_idle", '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Mini-SRC control unit; sits directly upstream of Datapath and drives every control strobe that the Datapath consumes.
- Steps a Moore FSM through fetch (T0-T2) and per-opcode execute steps (T3-T7), decoding IR[31:27].
- Returns to T0 after each instruction, or to HALTED on a halt instruction or an external stop.

Parameters:
- OPW, 5, opcode width taken from IR[31:27].

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- ir_op  in  OPW  IR[31:27] from Datapath IR register.
- con_ff  in  1  CON flip-flop output from Datapath.
- stop  in  1  external stop request, level.
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout  out  1 each  bus-drive strobes.
- PCin, MARin, MDRin, IRin, Yin, Zhighin, Zlowin, HIin, LOin, OutPortin, InPortin, CONin, Rin  out  1 each  register-load strobes.
- Gra, Grb, Grc  out  1 each  register-field selects.
- IncPC, Read, Write  out  1 each  PC increment and memory strobes.
- run  out  1  high while executing; low in RESET and HALTED.

Behaviour:
- States: RESET, T0-T7, HALTED.
- One state per clock; all outputs decode from the state register only, plus con_ff in the BR T6 step. No glitch-relevant inputs.
- clear high at any time, mid-instruction included: state goes to RESET immediately. All outputs 0, run 0.
- After clear falls, RESET lasts one clock, then T0.
- Fetch (all opcodes):
  - T0: PCout MARin IncPC PCin.
  - T1: Read MDRin.
  - T2: MDRout IRin.
- Execute; opcode is sampled from ir_op in T3 onward:
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010: T3 Grb Rout Yin; T4 Grc Rout Zlowin; T5 Zlowout Gra Rin.
  - addi 01011, andi 01100, ori 01101: T3 Grb Rout Yin; T4 Cout Zlowin; T5 Zlowout Gra Rin.
  - mul 01110, div 01111: T3 Gra Rout Yin; T4 Grb Rout Zlowin Zhighin; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg 10000, not 10001: T3 Grb Rout Zlowin; T4 Zlowout Gra Rin.
  - ld 00000: T3 Grb BAout Yin; T4 Cout Zlowin; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - ldi 00001: T3 Grb BAout Yin; T4 Cout Zlowin; T5 Zlowout Gra Rin.
  - st 00010: T3-T5 as ld; T6 Gra Rout MDRin (Read=0); T7 Write.
  - br 10010: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zlowin; T6 Zlowout PCin only if con_ff=1, otherwise no strobes.
  - jr 10011: T3 Gra Rout PCin.
  - jal 10100: T3 PCout Grb Rin (link register encoded in rb); T4 Gra Rout PCin.
  - in 10101: T3 InPortout Gra Rin.
  - out 10110: T3 Gra Rout OutPortin.
  - mfhi 10111: T3 HIout Gra Rin.
  - mflo 11000: T3 LOout Gra Rin.
  - nop 11001 and unused 11011-11111: T3 with no strobes.
  - halt 11010: T3 with no strobes, then HALTED.
- The last step of each instruction transitions to T0, or to HALTED if stop=1 at that edge.
- stop is ignored in all other states; the current instruction always completes.
- HALTED: all strobes 0, run 0; exit only via clear.
- At most one bus driver is asserted per state.
- Read and Write are never high together.

Test Plan:
- clear pulse mid-ld at T5 -> next sample shows all strobes 0, run 0; after release, RESET for 1 cycle, then T0 with PCout=MARin=IncPC=PCin=1.
- jr, ir_op=10011, PC=13, R6=27 -> T0, T1, T2, T3 with Gra Rout PCin high exactly 1 cycle; next cycle T0 drives PC 27.
- br, ir_op=10010, con_ff=0 then 1 -> T6 asserts no strobes for con_ff=0 and Zlowout PCin for con_ff=1; both runs then return to T0.
- st, ir_op=00010 -> T6 MDRin=1 with Read=0; T7 Write=1 for 1 cycle; Read and Write never coincide at any point.
- mul, ir_op=01110 -> LOin in T5 and HIin in T6, each 1 cycle; 7 clocks from T0 back to T0.
- halt (11010) -> run falls after T3 and strobes stay 0 for 20 cycles. Separately, an add with stop=1 -> enters HALTED after T5 instead of T0.
